// File: rtl/bram_phase_arbiter.sv
// Four-phase BRAM sequencer: one-hot fetch/data/write strobes plus arbitration of the
// single data slot per frame between the core load/store unit and a DMA requester.
module bram_phase_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [15:0] c_addr,
    input  logic [15:0] c_din,
    output logic        c_ack,
    output logic [15:0] c_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_din,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic        i1re,
    output logic        i2re,
    output logic        dre,
    output logic        gwe,
    output logic [15:0] daddr,
    output logic [15:0] din,
    output logic        dwe,
    input  logic [15:0] mem_dout
);

    // Handshake: a requester holds req/we/addr/din stable until its ack pulse; the
    // request is sampled only in P1, and a req still high after ack asks for the next frame.

    typedef enum logic [1:0] {
        PH_FETCH1 = 2'd0,
        PH_FETCH2 = 2'd1,
        PH_DATA   = 2'd2,
        PH_WRITE  = 2'd3
    } phase_e;

    localparam logic [3:0] STARVE_LIM4 = 4'(STARVE_LIMIT);

    phase_e      phase_q, phase_d;
    logic        i1re_q, i1re_d;
    logic        i2re_q, i2re_d;
    logic        dre_q, dre_d;
    logic        gwe_q, gwe_d;
    logic [15:0] daddr_q, daddr_d;
    logic [15:0] din_q, din_d;
    logic        dwe_q, dwe_d;
    logic        c_ack_q, c_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        gnt_c_q, gnt_c_d;
    logic        gnt_d_q, gnt_d_d;
    logic [3:0]  starve_q, starve_d;

    always_comb begin
        phase_d  = phase_e'(phase_q + 2'd1);
        i1re_d   = (phase_d == PH_FETCH1);
        i2re_d   = (phase_d == PH_FETCH2);
        dre_d    = (phase_d == PH_DATA);
        gwe_d    = (phase_d == PH_WRITE);
        daddr_d  = daddr_q;
        din_d    = din_q;
        dwe_d    = dwe_q;
        c_ack_d  = 1'b0;
        d_ack_d  = 1'b0;
        gnt_c_d  = gnt_c_q;
        gnt_d_d  = gnt_d_q;
        starve_d = starve_q;

        case (phase_q)
            PH_FETCH2: begin
                // Arbitration on the edge entering the data phase.
                gnt_c_d = 1'b0;
                gnt_d_d = 1'b0;
                dwe_d   = 1'b0;
                if (c_req && d_req) begin
                    if (starve_q >= STARVE_LIM4) begin
                        gnt_d_d  = 1'b1;
                        daddr_d  = d_addr;
                        din_d    = d_din;
                        dwe_d    = d_we;
                        starve_d = 4'd0;
                    end else begin
                        gnt_c_d  = 1'b1;
                        daddr_d  = c_addr;
                        din_d    = c_din;
                        dwe_d    = c_we;
                        if (starve_q != 4'hF) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                end else if (c_req) begin
                    gnt_c_d  = 1'b1;
                    daddr_d  = c_addr;
                    din_d    = c_din;
                    dwe_d    = c_we;
                    starve_d = 4'd0;
                end else if (d_req) begin
                    gnt_d_d  = 1'b1;
                    daddr_d  = d_addr;
                    din_d    = d_din;
                    dwe_d    = d_we;
                    starve_d = 4'd0;
                end else begin
                    starve_d = 4'd0;
                end
            end
            PH_DATA: begin
                c_ack_d = gnt_c_q;
                d_ack_d = gnt_d_q;
            end
            PH_WRITE: begin
                // Write enable stays up through gwe; the second write is a harmless repeat.
                dwe_d   = 1'b0;
                gnt_c_d = 1'b0;
                gnt_d_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= PH_WRITE;
            i1re_q   <= 1'b0;
            i2re_q   <= 1'b0;
            dre_q    <= 1'b0;
            gwe_q    <= 1'b0;
            daddr_q  <= 16'h0000;
            din_q    <= 16'h0000;
            dwe_q    <= 1'b0;
            c_ack_q  <= 1'b0;
            d_ack_q  <= 1'b0;
            gnt_c_q  <= 1'b0;
            gnt_d_q  <= 1'b0;
            starve_q <= 4'd0;
        end else begin
            phase_q  <= phase_d;
            i1re_q   <= i1re_d;
            i2re_q   <= i2re_d;
            dre_q    <= dre_d;
            gwe_q    <= gwe_d;
            daddr_q  <= daddr_d;
            din_q    <= din_d;
            dwe_q    <= dwe_d;
            c_ack_q  <= c_ack_d;
            d_ack_q  <= d_ack_d;
            gnt_c_q  <= gnt_c_d;
            gnt_d_q  <= gnt_d_d;
            starve_q <= starve_d;
        end
    end

    assign i1re    = i1re_q;
    assign i2re    = i2re_q;
    assign dre     = dre_q;
    assign gwe     = gwe_q;
    assign daddr   = daddr_q;
    assign din     = din_q;
    assign dwe     = dwe_q;
    assign c_ack   = c_ack_q;
    assign d_ack   = d_ack_q;
    // BRAM output is already registered; read data is meaningful only alongside an ack.
    assign c_rdata = mem_dout;
    assign d_rdata = mem_dout;

endmodule
